// File: rtl/hazard_control_unit.sv
// Hazard control unit for a five-stage pipeline.
// Turns load-use hazards, taken branches and data-memory wait states into
// stage-register enables, bubbles and flushes. A small FSM (RUN / MEM_WAIT /
// ERROR) tracks outstanding memory waits and traps a stuck memory as a sticky
// error that only reset clears.
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise stall_cnt, flush_cnt and wait_cnt are tied to zero.
//
// Handshake: the memory side is a plain request/ready pair. An access is
// pending while MEM_memReq is high and completes in the cycle MEM_memReady
// is high; the pipeline is frozen for every pending cycle that has not
// completed.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DE_EX_memRead,
  input  logic [4:0]       DE_EX_regRd,
  input  logic [4:0]       IF_DE_rs1,
  input  logic [4:0]       IF_DE_rs2,
  input  logic             RS1_USED,
  input  logic             RS2_USED,
  input  logic             EX_branchTaken,
  input  logic             MEM_memReq,
  input  logic             MEM_memReady,
  output logic             PC_write,
  output logic             IF_DE_write,
  output logic             DE_EX_write,
  output logic             EX_MEM_write,
  output logic             DE_EX_bubble,
  output logic             IF_DE_flush,
  output logic             DE_EX_flush,
  output logic             MEM_WB_bubble,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  // 11 bits holds the largest timeout (1023) plus one without wrapping.
  localparam int             TW = 11;
  localparam logic [TW-1:0]  TIMEOUT_L = MEM_TIMEOUT[TW-1:0];

  state_t        st;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_inc;
  logic          mem_wait;
  logic          load_use;
  logic          live;
  logic          stall_ev;
  logic          flush_ev;

  assign state    = st;
  assign tcnt_inc = tcnt + TW'(1);
  assign mem_wait = MEM_memReq && !MEM_memReady;
  assign load_use = DE_EX_memRead && (DE_EX_regRd != 5'd0) &&
                    ((RS1_USED && (DE_EX_regRd == IF_DE_rs1)) ||
                     (RS2_USED && (DE_EX_regRd == IF_DE_rs2)));

  // RUN and MEM_WAIT decode identically: a pending wait freezes, otherwise
  // the normal priority applies. ERROR always freezes. Reset forces idle.
  assign live     = !RST && (st != S_ERROR) && !mem_wait;
  assign flush_ev = live && EX_branchTaken;
  assign stall_ev = live && !EX_branchTaken && load_use;

  // Combinational control outputs from state and current inputs.
  always_comb begin
    PC_write      = 1'b1;
    IF_DE_write   = 1'b1;
    DE_EX_write   = 1'b1;
    EX_MEM_write  = 1'b1;
    DE_EX_bubble  = 1'b0;
    IF_DE_flush   = 1'b0;
    DE_EX_flush   = 1'b0;
    MEM_WB_bubble = 1'b0;
    if (!RST && ((st == S_ERROR) || mem_wait)) begin
      PC_write      = 1'b0;
      IF_DE_write   = 1'b0;
      DE_EX_write   = 1'b0;
      EX_MEM_write  = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (flush_ev) begin
      IF_DE_flush   = 1'b1;
      DE_EX_flush   = 1'b1;
    end else if (stall_ev) begin
      PC_write      = 1'b0;
      IF_DE_write   = 1'b0;
      DE_EX_bubble  = 1'b1;
    end
  end

  // FSM, wait timeout counter and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st   <= S_RUN;
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      case (st)
        S_RUN: begin
          if (mem_wait) begin
            tcnt <= TW'(1);
            if (TIMEOUT_L <= TW'(1)) begin
              st  <= S_ERROR;
              err <= 1'b1;
            end else begin
              st  <= S_MEM_WAIT;
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem_wait) begin
            tcnt <= tcnt_inc;
            if (tcnt_inc >= TIMEOUT_L) begin
              st  <= S_ERROR;
              err <= 1'b1;
            end
          end else begin
            st   <= S_RUN;
            tcnt <= '0;
          end
        end
        S_ERROR: begin
          err <= 1'b1;
        end
        default: begin
          st   <= S_RUN;
          tcnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] wait_q;

  // Saturating event counters: stalls, branch flushes, frozen-state cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      if (stall_ev && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_ev && (flush_q != '1)) flush_q <= flush_q + 1'b1;
      if ((st != S_RUN) && (wait_q != '1)) wait_q <= wait_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign wait_cnt  = wait_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural
// model that tracks pipeline mode and the length of the current wait run.
module tb_hazard_control_unit;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CMAX        = (1 << CNT_W) - 1;
`ifdef HAZARD_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  // {PC_write, IF_DE_write, DE_EX_write, EX_MEM_write,
  //  DE_EX_bubble, IF_DE_flush, DE_EX_flush, MEM_WB_bubble}
  localparam logic [7:0] V_IDLE   = 8'b1111_0000;
  localparam logic [7:0] V_FREEZE = 8'b0000_0001;
  localparam logic [7:0] V_FLUSH  = 8'b1111_0110;
  localparam logic [7:0] V_STALL  = 8'b0011_1000;

  logic             CLK = 1'b0;
  logic             RST;
  logic             DE_EX_memRead;
  logic [4:0]       DE_EX_regRd;
  logic [4:0]       IF_DE_rs1;
  logic [4:0]       IF_DE_rs2;
  logic             RS1_USED;
  logic             RS2_USED;
  logic             EX_branchTaken;
  logic             MEM_memReq;
  logic             MEM_memReady;
  logic             PC_write;
  logic             IF_DE_write;
  logic             DE_EX_write;
  logic             EX_MEM_write;
  logic             DE_EX_bubble;
  logic             IF_DE_flush;
  logic             DE_EX_flush;
  logic             MEM_WB_bubble;
  logic [1:0]       state;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];

  // Model state: mode (0 run, 1 waiting, 2 error), consecutive wait cycles,
  // and the three statistics totals.
  int m_state = 0;
  int m_run   = 0;
  int m_stall = 0;
  int m_flush = 0;
  int m_wait  = 0;

  hazard_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .DE_EX_memRead(DE_EX_memRead), .DE_EX_regRd(DE_EX_regRd),
    .IF_DE_rs1(IF_DE_rs1), .IF_DE_rs2(IF_DE_rs2),
    .RS1_USED(RS1_USED), .RS2_USED(RS2_USED),
    .EX_branchTaken(EX_branchTaken),
    .MEM_memReq(MEM_memReq), .MEM_memReady(MEM_memReady),
    .PC_write(PC_write), .IF_DE_write(IF_DE_write),
    .DE_EX_write(DE_EX_write), .EX_MEM_write(EX_MEM_write),
    .DE_EX_bubble(DE_EX_bubble), .IF_DE_flush(IF_DE_flush),
    .DE_EX_flush(DE_EX_flush), .MEM_WB_bubble(MEM_WB_bubble),
    .state(state), .err(err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  // Clock: posedge at 5, negedge at 10, period 10.
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Scoreboard: model predicts, compare pops and checks every cycle.
  always @(negedge CLK) begin
    logic [7:0] e;
    logic [7:0] got;
    bit waiting, lu, br;
    #1;
    waiting = MEM_memReq && !MEM_memReady;
    br      = EX_branchTaken;
    lu      = DE_EX_memRead && (DE_EX_regRd != 0) &&
              ((RS1_USED && DE_EX_regRd == IF_DE_rs1) ||
               (RS2_USED && DE_EX_regRd == IF_DE_rs2));
    if (RST) begin
      m_state = 0; m_run = 0; m_stall = 0; m_flush = 0; m_wait = 0;
      e = V_IDLE;
    end else if (m_state == 2 || waiting) e = V_FREEZE;
    else if (br)                          e = V_FLUSH;
    else if (lu)                          e = V_STALL;
    else                                  e = V_IDLE;
    exp_q.push_back(e);

    got = {PC_write, IF_DE_write, DE_EX_write, EX_MEM_write,
           DE_EX_bubble, IF_DE_flush, DE_EX_flush, MEM_WB_bubble};
    chk("ctrl", 32'(got), 32'(exp_q.pop_front()));
    chk("state", 32'(state), 32'(m_state));
    chk("err", 32'(err), 32'(m_state == 2));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    chk("wait_cnt", 32'(wait_cnt), 32'(m_wait));

    if (!RST) begin
      if (STATS != 0) begin
        m_stall = sat(m_stall + ((e == V_STALL) ? 1 : 0));
        m_flush = sat(m_flush + ((e == V_FLUSH) ? 1 : 0));
        m_wait  = sat(m_wait + ((m_state != 0) ? 1 : 0));
      end
      if (m_state != 2) begin
        if (waiting) begin
          m_run   = m_run + 1;
          m_state = (m_run >= MEM_TIMEOUT) ? 2 : 1;
        end else begin
          m_run   = 0;
          m_state = 0;
        end
      end
    end
  end

  task automatic set_idle();
    DE_EX_memRead  = 1'b0;
    DE_EX_regRd    = 5'd0;
    IF_DE_rs1      = 5'd0;
    IF_DE_rs2      = 5'd0;
    RS1_USED       = 1'b0;
    RS2_USED       = 1'b0;
    EX_branchTaken = 1'b0;
    MEM_memReq     = 1'b0;
    MEM_memReady   = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs2, input logic used2);
    set_idle();
    DE_EX_memRead = 1'b1;
    DE_EX_regRd   = rd;
    IF_DE_rs2     = rs2;
    RS2_USED      = used2;
  endtask

  // Reset for one full cycle, checking the in-reset outputs, then release.
  task automatic reset_pulse();
    @(negedge CLK);
    RST = 1'b1;
    set_idle();
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wait_cnt", 32'(wait_cnt), 32'd0);
    chk("rst_pc_write", 32'(PC_write), 32'd1);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic randomize_inputs(input int p_req, input int p_rdy);
    DE_EX_memRead  = ($urandom_range(0, 99) < 50);
    DE_EX_regRd    = 5'($urandom_range(0, 3));
    IF_DE_rs1      = 5'($urandom_range(0, 3));
    IF_DE_rs2      = 5'($urandom_range(0, 3));
    RS1_USED       = ($urandom_range(0, 99) < 60);
    RS2_USED       = ($urandom_range(0, 99) < 60);
    EX_branchTaken = ($urandom_range(0, 99) < 20);
    MEM_memReq     = ($urandom_range(0, 99) < p_req);
    MEM_memReady   = ($urandom_range(0, 99) < p_rdy);
  endtask

  initial begin
    RST = 1'b1;
    set_idle();
    @(negedge CLK);
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_pc_write", 32'(PC_write), 32'd1);

    // Load-use on rs2: one stall cycle.
    @(negedge CLK);
    RST = 1'b0;
    set_lu(5'd5, 5'd5, 1'b1);
    #2;
    chk("lu_pc_write", 32'(PC_write), 32'd0);
    chk("lu_if_de_write", 32'(IF_DE_write), 32'd0);
    chk("lu_bubble", 32'(DE_EX_bubble), 32'd1);
    chk("lu_de_ex_write", 32'(DE_EX_write), 32'd1);
    @(negedge CLK);
    set_idle();
    #2;
    chk("lu_stall_cnt", 32'(stall_cnt), 32'(STATS));
    chk("lu_after_pc_write", 32'(PC_write), 32'd1);

    // rs2 not used, then destination x0: no stall.
    @(negedge CLK);
    set_lu(5'd5, 5'd5, 1'b0);
    #2;
    chk("nouse_pc_write", 32'(PC_write), 32'd1);
    chk("nouse_bubble", 32'(DE_EX_bubble), 32'd0);
    @(negedge CLK);
    set_lu(5'd0, 5'd0, 1'b1);
    #2;
    chk("x0_pc_write", 32'(PC_write), 32'd1);

    // Branch wins over load-use.
    @(negedge CLK);
    set_lu(5'd5, 5'd5, 1'b1);
    EX_branchTaken = 1'b1;
    #2;
    chk("br_if_de_flush", 32'(IF_DE_flush), 32'd1);
    chk("br_de_ex_flush", 32'(DE_EX_flush), 32'd1);
    chk("br_pc_write", 32'(PC_write), 32'd1);
    chk("br_bubble", 32'(DE_EX_bubble), 32'd0);
    @(negedge CLK);
    set_idle();
    #2;
    chk("br_flush_cnt", 32'(flush_cnt), 32'(STATS));
    chk("br_stall_cnt", 32'(stall_cnt), 32'(STATS));

    // Three wait cycles then ready; branch/load-use ignored while waiting.
    reset_pulse();
    set_idle();
    MEM_memReq = 1'b1;
    #2;
    chk("w1_state", 32'(state), 32'd0);
    chk("w1_pc_write", 32'(PC_write), 32'd0);
    chk("w1_wb_bubble", 32'(MEM_WB_bubble), 32'd1);
    @(negedge CLK);
    set_lu(5'd5, 5'd5, 1'b1);
    EX_branchTaken = 1'b1;
    MEM_memReq     = 1'b1;
    #2;
    chk("w2_state", 32'(state), 32'd1);
    chk("w2_flush", 32'(IF_DE_flush), 32'd0);
    chk("w2_ex_mem_write", 32'(EX_MEM_write), 32'd0);
    @(negedge CLK);
    set_idle();
    MEM_memReq = 1'b1;
    #2;
    chk("w3_state", 32'(state), 32'd1);
    @(negedge CLK);
    MEM_memReady = 1'b1;
    #2;
    chk("w4_state", 32'(state), 32'd1);
    chk("w4_pc_write", 32'(PC_write), 32'd1);
    chk("w4_wb_bubble", 32'(MEM_WB_bubble), 32'd0);
    @(negedge CLK);
    set_idle();
    #2;
    chk("w5_state", 32'(state), 32'd0);
    chk("w5_wait_cnt", 32'(wait_cnt), 32'(3 * STATS));

    // Memory never ready: ERROR after the fourth waiting cycle.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      MEM_memReq = 1'b1;
      #2;
      chk("to_state", 32'(state), 32'((i == 0) ? 0 : 1));
      @(negedge CLK);
    end
    #2;
    chk("to_err_state", 32'(state), 32'd2);
    chk("to_err", 32'(err), 32'd1);
    @(negedge CLK);
    set_idle();
    MEM_memReady   = 1'b1;
    EX_branchTaken = 1'b1;
    #2;
    chk("err_hold_state", 32'(state), 32'd2);
    chk("err_pc_write", 32'(PC_write), 32'd0);
    chk("err_wb_bubble", 32'(MEM_WB_bubble), 32'd1);
    chk("err_flush", 32'(IF_DE_flush), 32'd0);
    reset_pulse();
    set_idle();
    #2;
    chk("post_err_state", 32'(state), 32'd0);
    chk("post_err_err", 32'(err), 32'd0);
    chk("post_err_pc_write", 32'(PC_write), 32'd1);

    // Randomized traffic; alternate light and heavy memory-wait phases.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      RST = ($urandom_range(0, 63) == 0);
      if ((c / 500) % 2 == 0) randomize_inputs(30, 50);
      else                    randomize_inputs(80, 20);
    end

    @(negedge CLK);
    RST = 1'b0;
    set_idle();
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
